reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer_pkg.sv | 25 ++
 rtl/reset_sequencer_sync.sv | 31 +++
 rtl/reset_sequencer.sv | 143 ++++++++++++++
 tb/tb_reset_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Purpose : shared types and constants for the staged reset / boot controller.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package reset_sequencer_pkg;

    // Datapath width of the core the boot PC feeds.
    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PC_START_DEFAULT = 32'h0000_0400;

    typedef enum logic [1:0] {
        RSTSEQ_HOLD    = 2'd0,
        RSTSEQ_STAGGER = 2'd1,
        RSTSEQ_RUN     = 2'd2
    } rstseq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync.sv
// Purpose : async-assert / sync-deassert reset synchroniser, usable in any clock domain.
// Latency : rst_sync falls on the STAGES-th clk edge after rst falls; rises immediately with rst.
// Backpr. : none; level output.
// Ports   : clk, rst (async active-high in), rst_sync (active-high out, released synchronously).
module reset_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_sync
);

    if (STAGES < 2) begin : g_bad_stages
        $error("reset_sync: STAGES must be >= 2");
    end

    logic [STAGES-1:0] chain;

    // Every flop is async-set so the output asserts without a clock; zeros
    // ripple in from the bottom once rst drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Purpose : staged reset release (channel 0 first) with boot PC and software warm reset.
// Latency : channel i releases SYNC_STAGES+HOLD_CYCLES+i*STAGGER_CYCLES edges after reset falls
//           (HOLD_CYCLES+i*STAGGER_CYCLES after a warm request); ready rises with the last channel.
// Backpr. : none; a held sw_reset_req keeps restarting the hold phase.
// Ports   : clk, reset (async active-high), sw_reset_req/sw_boot_pc (warm request + PC),
//           rst_out (per-channel active-high), boot_pc, ready, warm.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int              NUM_CHANNELS   = 3,
    parameter int              SYNC_STAGES    = 2,
    parameter int              HOLD_CYCLES    = 3,
    parameter int              STAGGER_CYCLES = 2,
    parameter logic [XLEN-1:0] PC_START       = PC_START_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sw_reset_req,
    input  logic [XLEN-1:0]         sw_boot_pc,
    output logic [NUM_CHANNELS-1:0] rst_out,
    output logic [XLEN-1:0]         boot_pc,
    output logic                    ready,
    output logic                    warm
);

    if ((NUM_CHANNELS < 1) || (HOLD_CYCLES < 1) || (SYNC_STAGES < 2) || (STAGGER_CYCLES < 0)) begin : g_bad_params
        $error("reset_sequencer: illegal parameter combination");
    end

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, STAGGER_CYCLES, 1) + 1);
    localparam int IDX_W = $clog2(NUM_CHANNELS + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CHANNELS - 1);

    logic rst_sync;

    reset_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (reset),
        .rst_sync (rst_sync)
    );

    rstseq_state_t            state, state_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [IDX_W-1:0]         idx, idx_nxt;
    logic [NUM_CHANNELS-1:0]  rst_nxt;
    logic                     ready_nxt;
    logic                     warm_nxt;
    logic [XLEN-1:0]          pc_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RSTSEQ_HOLD;
            cnt     <= '0;
            idx     <= '0;
            rst_out <= '1;
            ready   <= 1'b0;
            warm    <= 1'b0;
            boot_pc <= PC_START;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            rst_out <= rst_nxt;
            ready   <= ready_nxt;
            warm    <= warm_nxt;
            boot_pc <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        rst_nxt   = rst_out;
        ready_nxt = ready;
        warm_nxt  = warm;
        pc_nxt    = boot_pc;

        if (rst_sync) begin
            // Synchroniser still draining: registers sit at their cold values.
            state_nxt = RSTSEQ_HOLD;
        end else if (sw_reset_req) begin
            // Warm restart from any state; the synchroniser is not re-run.
            state_nxt = RSTSEQ_HOLD;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            rst_nxt   = '1;
            ready_nxt = 1'b0;
            warm_nxt  = 1'b1;
            pc_nxt    = sw_boot_pc;
        end else begin
            unique case (state)
                RSTSEQ_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt_nxt    = '0;
                        idx_nxt    = IDX_W'(1);
                        rst_nxt[0] = 1'b0;
                        if (NUM_CHANNELS == 1) begin
                            state_nxt = RSTSEQ_RUN;
                            ready_nxt = 1'b1;
                        end else if (STAGGER_CYCLES == 0) begin
                            // No stagger: every channel goes with channel 0.
                            rst_nxt   = '0;
                            state_nxt = RSTSEQ_RUN;
                            ready_nxt = 1'b1;
                        end else begin
                            state_nxt = RSTSEQ_STAGGER;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RSTSEQ_STAGGER: begin
                    if (cnt == STAG_LAST) begin
                        cnt_nxt = '0;
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            if (IDX_W'(i) == idx) rst_nxt[i] = 1'b0;
                        end
                        idx_nxt = idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state_nxt = RSTSEQ_RUN;
                            ready_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RSTSEQ_RUN: begin
                    state_nxt = RSTSEQ_RUN;
                end
                default: begin
                    state_nxt = RSTSEQ_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Purpose : randomized + directed bench for reset_sequencer, two configurations side by side.
// Latency : expected values are sampled once per cycle on the falling clock edge.
// Backpr. : n/a.
module tb_reset_sequencer;

    localparam int          SYNC     = 2;
    localparam int          HOLD     = 3;
    localparam logic [31:0] PC_COLD  = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sw_reset_req = 1'b0;
    logic [31:0] sw_boot_pc = '0;

    logic [2:0]  rst_a;
    logic [31:0] pc_a;
    logic        ready_a, warm_a;
    logic [3:0]  rst_b;
    logic [31:0] pc_b;
    logic        ready_b, warm_b;

    always #5 clk = ~clk;

    reset_sequencer dut_a (
        .clk          (clk),
        .reset        (reset),
        .sw_reset_req (sw_reset_req),
        .sw_boot_pc   (sw_boot_pc),
        .rst_out      (rst_a),
        .boot_pc      (pc_a),
        .ready        (ready_a),
        .warm         (warm_a)
    );

    reset_sequencer #(
        .NUM_CHANNELS   (4),
        .STAGGER_CYCLES (0)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .sw_reset_req (sw_reset_req),
        .sw_boot_pc   (sw_boot_pc),
        .rst_out      (rst_b),
        .boot_pc      (pc_b),
        .ready        (ready_b),
        .warm         (warm_b)
    );

    typedef struct packed {
        logic [3:0]  rst;
        logic        ready;
        logic        warm;
        logic [31:0] pc;
    } obs_t;

    obs_t q_a[$];
    obs_t q_b[$];
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;

    // Reference model: the sequence is described only by how many edges have
    // elapsed since its origin and when each channel is due to release.
    int          m_t      = 0;
    int          m_base   = SYNC + HOLD;
    bit          m_synced = 1'b0;
    bit          m_warm   = 1'b0;
    logic [31:0] m_pc     = PC_COLD;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t      = 0;
            m_base   = SYNC + HOLD;
            m_synced = 1'b0;
            m_warm   = 1'b0;
            m_pc     = PC_COLD;
        end else if (m_synced && sw_reset_req) begin
            m_t    = 0;
            m_base = HOLD;
            m_warm = 1'b1;
            m_pc   = sw_boot_pc;
        end else begin
            if (m_t < 10000) m_t++;
            if (m_t >= SYNC) m_synced = 1'b1;
        end
    end

    function automatic obs_t model_obs(input int num, input int stag);
        obs_t o;
        o.rst = '0;
        for (int i = 0; i < num; i++) begin
            if (m_t < m_base + i * stag) o.rst[i] = 1'b1;
        end
        o.ready = (o.rst == 4'b0000);
        o.warm  = m_warm;
        o.pc    = m_pc;
        return o;
    endfunction

    // Expected side: one entry per sample point for each configuration.
    always @(negedge clk) begin
        if (!done) begin
            q_a.push_back(model_obs(3, 2));
            q_b.push_back(model_obs(4, 0));
        end
    end

    task automatic compare(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s @%0t got rst=%b ready=%b warm=%b pc=%h, required rst=%b ready=%b warm=%b pc=%h",
                     name, $time, got.rst, got.ready, got.warm, got.pc,
                     exp.rst, exp.ready, exp.warm, exp.pc);
        end
    endtask

    // Monitor: pops the expected entry for each sample point and compares.
    always @(negedge clk) begin
        obs_t ga, gb, ea, eb;
        #1;
        if (!done) begin
            ga = '{rst: {1'b0, rst_a}, ready: ready_a, warm: warm_a, pc: pc_a};
            gb = '{rst: rst_b, ready: ready_b, warm: warm_b, pc: pc_b};
            if (q_a.size() == 0 || q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty @%0t got sizes %0d/%0d, required nonzero", $time, q_a.size(), q_b.size());
            end else begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                compare("cfg_default", ga, ea);
                compare("cfg_4ch_nostagger", gb, eb);
            end
        end
    end

    // Advance n rising edges, then move 2 time units past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cold_reset(input int cycles);
        reset = 1'b1;
        tick(cycles);
        reset = 1'b0;
    endtask

    initial begin
        // Cold boot with defaults.
        tick(4);
        reset = 1'b0;
        tick(12);

        // Warm request while running.
        sw_boot_pc   = 32'h0000_2000;
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        tick(12);

        // Warm request sampled on edge 6 of a cold sequence.
        cold_reset(3);
        tick(5);
        sw_boot_pc   = 32'h0000_0800;
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        tick(12);

        // Async reset between edges during the stagger phase.
        cold_reset(2);
        tick(7);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(12);

        // Reset and warm request together: cold wins.
        sw_boot_pc   = 32'h0000_1234;
        sw_reset_req = 1'b1;
        reset        = 1'b1;
        tick(2);
        reset        = 1'b0;
        sw_reset_req = 1'b0;
        tick(12);

        // Held request keeps the outputs asserted.
        sw_boot_pc   = 32'h0000_3000;
        sw_reset_req = 1'b1;
        tick(6);
        sw_reset_req = 1'b0;
        tick(12);

        // Randomized phase.
        for (int c = 0; c < 500; c++) begin
            tick(1);
            sw_reset_req = ($urandom_range(0, 9) == 0);
            sw_boot_pc   = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 59) == 0) begin
                reset = 1'b1;
            end else if (reset && $urandom_range(0, 1) == 1) begin
                reset = 1'b0;
            end
        end
        reset        = 1'b0;
        sw_reset_req = 1'b0;
        tick(15);

        @(negedge clk);
        #3;
        done = 1'b1;
        #10;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
